// File: rtl/majority_pkg.sv
// Shared constants for the majority vote sequencer: FSM state encoding and width.
package majority_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_COLLECT = 2'd1;
  localparam logic [STATE_W-1:0] ST_EVAL    = 2'd2;
  localparam logic [STATE_W-1:0] ST_HOLD    = 2'd3;

endpackage

// File: rtl/majority_gate_n_bit.sv
// Combinational majority gate: high iff strictly more than n/2 of the n inputs are 1.
module majority_gate_n_bit #(
  parameter int n = 8
) (
  input  logic [n:1] votes,
  output logic       majority
);

  int ones;

  always_comb begin
    ones = 0;
    for (int i = 1; i <= n; i++) begin
      ones = ones + int'(votes[i]);
    end
    majority = (ones > n / 2);
  end

endmodule

// File: rtl/majority_vote_sequencer.sv
// Collects up to N single-bit votes per round (or until an idle timeout),
// then presents the majority decision until the consumer takes it.
module majority_vote_sequencer
  import majority_pkg::*;
#(
  parameter int N       = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     vote_valid,
  input  logic                     vote_bit,
  output logic                     vote_ready,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic                     result,
  output logic                     timed_out,
  output logic [$clog2(N+1)-1:0]   vote_count,
  output logic                     busy,
  output logic [STATE_W-1:0]       state_dbg
);

  localparam int CW = $clog2(N + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [STATE_W-1:0] state;
  logic [N:1]         votes;
  logic [TW-1:0]      idle_timer;
  logic               majority;

  // Handshakes: a vote transfers on a cycle with vote_valid && vote_ready;
  // a result transfers on a cycle with result_valid && result_ready.
  // Neither ready nor valid depends combinationally on the other side.
  assign vote_ready   = (state == ST_COLLECT);
  assign result_valid = (state == ST_HOLD);
  assign busy         = (state != ST_IDLE);
  assign state_dbg    = state;

  majority_gate_n_bit #(.n(N)) u_gate (
    .votes    (votes),
    .majority (majority)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      votes      <= '0;
      vote_count <= '0;
      idle_timer <= '0;
      result     <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_COLLECT;
            votes      <= '0;
            vote_count <= '0;
            idle_timer <= '0;
            timed_out  <= 1'b0;
          end
        end
        ST_COLLECT: begin
          // An accepted vote always beats a timeout landing on the same cycle.
          if (vote_valid) begin
            for (int i = 1; i <= N; i++) begin
              if (i == int'(vote_count) + 1) votes[i] <= vote_bit;
            end
            vote_count <= vote_count + CW'(1);
            idle_timer <= '0;
            if (int'(vote_count) + 1 == N) state <= ST_EVAL;
          end else begin
            idle_timer <= idle_timer + TW'(1);
            if (int'(idle_timer) + 1 == TIMEOUT) begin
              state     <= ST_EVAL;
              timed_out <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          result <= majority;
          state  <= ST_HOLD;
        end
        ST_HOLD: begin
          if (result_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_majority_vote_sequencer.sv
// Directed and randomized rounds against a round-level model of the majority vote sequencer.
module tb_majority_vote_sequencer;

  localparam int N  = 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vote_valid;
  logic       vote_bit;
  logic       vote_ready;
  logic       result_valid;
  logic       result_ready;
  logic       result;
  logic       timed_out;
  logic [3:0] vote_count;
  logic       busy;
  logic [1:0] state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  bit stim_v[$];
  bit stim_b[$];

  majority_vote_sequencer #(.N(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_bit     (vote_bit),
    .vote_ready   (vote_ready),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .timed_out    (timed_out),
    .vote_count   (vote_count),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vote_ready"}, vote_ready, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_timed_out"}, timed_out, 0);
    check({tag, "_vote_count"}, vote_count, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // driver helpers
  task automatic push_vote(input bit b, input int gap);
    repeat (gap) begin
      stim_v.push_back(1'b0);
      stim_b.push_back(1'($urandom_range(0, 1)));
    end
    stim_v.push_back(1'b1);
    stim_b.push_back(b);
  endtask

  task automatic push_bits(input logic [7:0] bits, input int count);
    logic [7:0] v;
    v = bits;
    for (int i = 0; i < count; i++) push_vote(v[7-i], 0);
  endtask

  // Plays the queued stimulus as one round; the model ends the round after N
  // accepted votes or TO consecutive idle cycles and predicts the outcome.
  task automatic run_round(input string tag, input int hold_cycles, input bit poke_start);
    bit acc[$];
    int idle;
    int ones;
    bit to_flag;
    bit done;
    bit exp_res;
    bit v;
    bit b;

    check({tag, "_pre_busy"}, busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_ready"}, vote_ready, 1);
    check({tag, "_start_count"}, vote_count, 0);
    check({tag, "_start_timed_out"}, timed_out, 0);

    idle = 0;
    done = 1'b0;
    to_flag = 1'b0;
    while (!done) begin
      if (stim_v.size() > 0) begin
        v = stim_v.pop_front();
        b = stim_b.pop_front();
      end else begin
        v = 1'b0;
        b = 1'($urandom_range(0, 1));
      end
      check({tag, "_collect_ready"}, vote_ready, 1);
      vote_valid = v;
      vote_bit   = b;
      tick();
      if (v) begin
        acc.push_back(b);
        idle = 0;
        if (acc.size() == N) done = 1'b1;
      end else begin
        idle++;
        if (idle == TO) begin
          done = 1'b1;
          to_flag = 1'b1;
        end
      end
    end
    stim_v.delete();
    stim_b.delete();

    ones = 0;
    foreach (acc[i]) ones += int'(acc[i]);
    exp_res = (ones > N / 2);

    // evaluation cycle: no vote acceptance, no result yet
    check({tag, "_eval_ready"}, vote_ready, 0);
    check({tag, "_eval_rvalid"}, result_valid, 0);
    check({tag, "_eval_busy"}, busy, 1);
    vote_valid = 1'b1;
    vote_bit   = 1'b1;
    tick();

    check({tag, "_rvalid"}, result_valid, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_timed_out"}, timed_out, to_flag);
    check({tag, "_count"}, vote_count, acc.size());

    repeat (hold_cycles) begin
      start        = poke_start;
      vote_valid   = 1'($urandom_range(0, 1));
      vote_bit     = 1'($urandom_range(0, 1));
      result_ready = 1'b0;
      tick();
      check({tag, "_hold_rvalid"}, result_valid, 1);
      check({tag, "_hold_ready"}, vote_ready, 0);
      check({tag, "_hold_result"}, result, exp_res);
      check({tag, "_hold_timed_out"}, timed_out, to_flag);
      check({tag, "_hold_count"}, vote_count, acc.size());
    end

    start        = poke_start;
    result_ready = 1'b1;
    vote_valid   = 1'b0;
    tick();
    start        = 1'b0;
    check({tag, "_idle_rvalid"}, result_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_result"}, result, exp_res);
    check({tag, "_idle_timed_out"}, timed_out, to_flag);

    // stray handshakes while idle must not disturb anything
    vote_valid = 1'b1;
    tick();
    vote_valid   = 1'b0;
    result_ready = 1'b0;
    check({tag, "_idle2_busy"}, busy, 0);
    check({tag, "_idle2_count"}, vote_count, acc.size());
    check({tag, "_idle2_ready"}, vote_ready, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    vote_valid   = 1'b0;
    vote_bit     = 1'b0;
    result_ready = 1'b0;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    push_bits(8'b1111_1000, 8);
    run_round("majority_yes", 2, 1'b0);

    push_bits(8'b1111_0000, 8);
    run_round("tie", 1, 1'b0);

    push_bits(8'b1111_1000, 5);
    run_round("timeout_yes", 0, 1'b0);

    push_bits(8'b1110_0000, 3);
    run_round("timeout_no", 0, 1'b0);

    push_bits(8'b1010_1011, 8);
    run_round("hold_long", 10, 1'b1);

    // gaps of TO-1 idle cycles keep the round alive
    push_vote(1'b1, 0);
    push_vote(1'b1, 3);
    push_vote(1'b1, 3);
    push_vote(1'b0, 3);
    push_vote(1'b1, 3);
    run_round("timer_edge", 1, 1'b0);

    // mid-round reset discards the partial round
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vote_valid = 1'b1;
      vote_bit   = 1'b1;
      tick();
    end
    vote_valid = 1'b0;
    check("midround_count", vote_count, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_vals("midreset");
    push_bits(8'b1111_1000, 8);
    run_round("after_reset", 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int nv;
      nv = $urandom_range(1, N);
      for (int i = 0; i < nv; i++) begin
        int gap;
        gap = ($urandom_range(0, 9) == 0) ? TO : $urandom_range(0, TO - 1);
        push_vote(1'($urandom_range(0, 1)), gap);
      end
      run_round("random", $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
